// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and the
// IF/ID pipeline register fields handed to decode.
interface fetch_stage_if;
    localparam int unsigned XLEN = 32;

    // Instruction memory (combinational read)
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;

    // Hazard unit and branch resolve
    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    // IF/ID register and status
    logic [XLEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic            if_id_valid;
    logic            fetch_fault;
    logic [XLEN-1:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  branch_taken,
        input  branch_target,
        output if_id_instr,
        output if_id_pc,
        output if_id_pc_plus4,
        output if_id_valid,
        output fetch_fault,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output branch_taken,
        output branch_target,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_pc_plus4,
        input  if_id_valid,
        input  fetch_fault,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC ownership, IF/ID capture, stall/redirect
// handling, sticky fault-halt on illegal PCs and a retired-fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master fif
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = '0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word_idx;
    logic            pc_bad;

    assign word_idx      = {2'b00, pc[XLEN-1:2]};
    assign fif.imem_addr = word_idx;

    // Misaligned or beyond memory; pc+4 wrap-around lands here too
    assign pc_bad = (pc[1:0] != 2'b00) || (word_idx >= XLEN'(IMEM_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= BOOT;
            pc                 <= RESET_PC;
            fif.if_id_instr    <= NOP;
            fif.if_id_pc       <= '0;
            fif.if_id_pc_plus4 <= '0;
            fif.if_id_valid    <= 1'b0;
            fif.fetch_fault    <= 1'b0;
            fif.fetch_count    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end

                RUN: begin
                    if (pc_bad) begin
                        fif.if_id_instr    <= NOP;
                        fif.if_id_pc       <= '0;
                        fif.if_id_pc_plus4 <= '0;
                        fif.if_id_valid    <= 1'b0;
                        fif.fetch_fault    <= 1'b1;
                        state              <= HALT;
                    end else if (fif.branch_taken) begin
                        // Squash the wrong-path word fetched this cycle
                        pc                 <= fif.branch_target;
                        fif.if_id_instr    <= NOP;
                        fif.if_id_pc       <= '0;
                        fif.if_id_pc_plus4 <= '0;
                        fif.if_id_valid    <= 1'b0;
                    end else if (!fif.stall) begin
                        fif.if_id_instr    <= fif.imem_instr;
                        fif.if_id_pc       <= pc;
                        fif.if_id_pc_plus4 <= pc + XLEN'(4);
                        fif.if_id_valid    <= 1'b1;
                        pc                 <= pc + XLEN'(4);
                        fif.fetch_count    <= fif.fetch_count + XLEN'(1);
                    end
                end

                HALT: begin
                    fif.if_id_instr    <= NOP;
                    fif.if_id_pc       <= '0;
                    fif.if_id_pc_plus4 <= '0;
                    fif.if_id_valid    <= 1'b0;
                    fif.fetch_fault    <= 1'b1;
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit MIPS pipeline. It owns the program counter and drives the word address into the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register consumed by decode. It handles load-use stalls, taken-branch redirects with wrong-path squash, a post-reset bubble, a sticky fault/halt on illegal PCs, and a retired-fetch counter.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_DEPTH, 128, number of 32-bit words in instruction memory; legal word indices are 0..IMEM_DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  word index to instruction memory, = {2'b00, pc[31:2]}, combinational from the PC.
- imem_instr  input  32  instruction returned combinationally by instruction memory for imem_addr.
- stall  input  1  hazard unit request to hold the PC and IF/ID.
- branch_taken  input  1  redirect request from the branch-resolve stage.
- branch_target  input  32  byte address to redirect to; sampled only when branch_taken=1.
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc  output  32  registered byte PC of if_id_instr.
- if_id_pc_plus4  output  32  registered if_id_pc+4.
- if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- fetch_fault  output  1  sticky; PC was misaligned or outside IMEM_DEPTH.
- fetch_count  output  32  number of instructions loaded into IF/ID with valid=1.

## Operation

- State machine with states BOOT, RUN, and HALT.
- Reset applies at any time, including mid-stall, mid-redirect, or in HALT. It sets:
  - pc to RESET_PC;
  - if_id_instr, if_id_pc, and if_id_pc_plus4 to 0 (NOP = sll $0,$0,0);
  - if_id_valid, fetch_fault, and fetch_count to 0;
  - state to BOOT.
- BOOT lasts exactly one cycle and ignores all inputs. IF/ID stays a bubble and pc holds. The next state is RUN.
- RUN evaluates these cases in priority order each cycle:
  1. Fault: pc[1:0]≠0 or pc[31:2]≥IMEM_DEPTH.
     - IF/ID gets the NOP with valid=0; fetch_fault is set to 1; pc holds.
     - Next state is HALT. Fault wins over stall and branch_taken.
  2. branch_taken:
     - pc gets branch_target.
     - IF/ID gets the NOP with valid=0, squashing the wrong-path instruction fetched this cycle.
     - Redirect wins over a simultaneous stall.
  3. stall: pc and all IF/ID outputs hold their values, including valid.
  4. Normal:
     - if_id_instr gets imem_instr; if_id_pc gets pc; if_id_pc_plus4 gets pc+4; if_id_valid gets 1.
     - pc gets pc+4 and fetch_count increments.
- HALT is left only by reset. It ignores stall and branch_taken. IF/ID stays a bubble, pc holds, and fetch_fault stays 1.
- Arithmetic:
  - pc+4 is 32-bit modulo; wrap-around is not special-cased, and the bound check catches it.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
  - branch_target is not checked at redirect; a bad target faults in the following RUN cycle.
- imem_addr is always driven from the current pc, including in BOOT and HALT.

## Timing

- Instruction memory is combinational, so an instruction is fetched and latched in the same cycle.
- Latency: the instruction at pc appears on if_id_* one edge after pc becomes current.
- After rst is deasserted:
  - Cycle 0 is BOOT.
  - Cycle 1 fetches from RESET_PC; if_id_valid=1 after the cycle-1 edge.
- Redirect cost: exactly one bubble. At edge N, branch_taken=1. At edge N+1, IF/ID holds the target instruction.
- Stall has zero extra latency. The cycle after stall drops, the held pc is fetched normally.
- All outputs are registered except imem_addr.

## Test plan

- Reset and boot: memory word0=32'h8C4A0005 and word1=32'h01465822; deassert rst.
  - After edge 1: valid=0, imem_addr=0.
  - After edge 2: if_id_instr=32'h8C4A0005, if_id_pc=0, if_id_pc_plus4=4, fetch_count=1.
  - After edge 3: if_id_instr=32'h01465822, fetch_count=2.
- Stall: in RUN with pc=8, hold stall=1 for 3 cycles.
  - if_id_* stays at word1 and pc stays 8.
  - After stall drops, the next edge loads word2 with if_id_pc=8.
- Branch: with pc=12, assert branch_taken=1 and branch_target=40 for one cycle, with stall=1 simultaneously.
  - Next edge: valid=0, pc=40.
  - Following edge: if_id_pc=40, if_id_instr=word10.
- Out-of-range fault: branch to 512 (word 128 with IMEM_DEPTH=128).
  - One edge later, fetch_fault=1, valid=0, and the state is HALT.
  - Further branch_taken pulses leave pc=512.
  - rst recovers with pc=RESET_PC and fetch_fault=0.
- Misaligned fault: branch_target=6 gives fetch_fault=1 on the edge after the redirect, and fetch_count does not increment.
- Reset mid-operation: assert rst during a stall with valid=1. Next edge: all outputs are 0, the state is BOOT, and the one-cycle bubble repeats.
